// File: rtl/cpu_pkg.sv
// Shared core types: widths, fetch FSM states and the fetch-address legality check.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] INSTR_BUBBLE = 32'h0;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

    // One extra bit keeps addr + 3 from wrapping for addresses near 2^64.
    function automatic logic addr_legal(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W:0]   mem_size
    );
        logic [ADDR_W:0] last;
        last = {1'b0, addr} + 65'd3;
        return (addr[1:0] == 2'b00) && (last < mem_size);
    endfunction

endpackage

// File: rtl/ifetch_perf.sv
// Saturating fetch performance counters (built only when IFETCH_PERF_EN is defined).
module ifetch_perf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_evt,
    input  logic        stall_evt,
    input  logic        flush_evt,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalls_q, stalls_d;
    logic [31:0] flushes_q, flushes_d;

    always_comb begin
        fetched_d = fetched_q;
        stalls_d  = stalls_q;
        flushes_d = flushes_q;
        if (fetch_evt && fetched_q != CNT_MAX) fetched_d = fetched_q + 32'd1;
        if (stall_evt && stalls_q != CNT_MAX) stalls_d = stalls_q + 32'd1;
        if (flush_evt && flushes_q != CNT_MAX) flushes_d = flushes_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
            flushes_q <= flushes_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM addressing, IF/ID register and fault trap.
// Optional perf counters enabled by defining IFETCH_PERF_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       MEM_SIZE = 1024,
    parameter logic [63:0]       RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               fetch_fault
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls,
    output logic [31:0]        perf_flushes
`endif
);

    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEM_SIZE);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               fault_q, fault_d;
    logic [ADDR_W-1:0]  pc_next;

    assign pc_next = pc_q + 64'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if_pc_d = if_pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b0;
            end
            RUN: begin
                if (br_taken) begin
                    valid_d = 1'b0;
                    if (addr_legal(br_target, MEM_LIM)) begin
                        pc_d = br_target;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end else if (!stall) begin
                    if_pc_d = pc_q;
                    instr_d = imem_instr;
                    valid_d = 1'b1;
                    // The last legal word still retires before the trap.
                    if (addr_legal(pc_next, MEM_LIM)) begin
                        pc_d = pc_next;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            if_pc_q <= '0;
            instr_q <= INSTR_BUBBLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            if_pc_q <= if_pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = instr_q;
    assign fetch_fault = fault_q;

`ifdef IFETCH_PERF_EN
    logic in_run;
    logic fetch_evt;
    logic stall_evt;
    logic flush_evt;

    assign in_run    = (state_q == RUN);
    assign fetch_evt = in_run && !br_taken && !stall;
    assign stall_evt = in_run && !br_taken && stall;
    assign flush_evt = in_run && br_taken && addr_legal(br_target, MEM_LIM);

    ifetch_perf u_perf (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch_evt    (fetch_evt),
        .stall_evt    (stall_evt),
        .flush_evt    (flush_evt),
        .perf_fetched (perf_fetched),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a reference model feeding a scoreboard queue.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int unsigned MEM_SIZE = 1024;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [64:0] LIM = 65'(MEM_SIZE);

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls, perf_flushes;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    fetch_state_t m_state;
    logic [63:0]  m_pc;
    logic         m_valid;
    logic [63:0]  m_ifpc;
    logic [31:0]  m_instr;
    logic         m_fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        return 32'hE3A0_0000 ^ a[31:0];
    endfunction

    assign imem_instr = rom(imem_addr);

    instr_fetch #(
        .MEM_SIZE (MEM_SIZE),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .fetch_fault (fetch_fault)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic br,
                        input logic [63:0] tgt);
        exp_t e;
        reset_n   = !rst;
        stall     = st;
        br_taken  = br;
        br_target = tgt;
        if (rst) begin
            m_state = BOOT;
            m_pc    = RESET_PC;
            m_valid = 1'b0;
            m_ifpc  = '0;
            m_instr = '0;
            m_fault = 1'b0;
        end else if (m_state == BOOT) begin
            m_state = RUN;
            m_valid = 1'b0;
        end else if (m_state == HALT) begin
            m_valid = 1'b0;
        end else if (br) begin
            m_valid = 1'b0;
            if (addr_legal(tgt, LIM)) m_pc = tgt;
            else begin
                m_state = HALT;
                m_fault = 1'b1;
            end
        end else if (!st) begin
            m_ifpc  = m_pc;
            m_instr = rom(m_pc);
            m_valid = 1'b1;
            if (addr_legal(m_pc + 64'd4, LIM)) m_pc = m_pc + 64'd4;
            else begin
                m_state = HALT;
                m_fault = 1'b1;
            end
        end
        e = '{addr: m_pc, valid: m_valid, pc: m_ifpc, instr: m_instr,
              fault: m_fault};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("imem_addr", imem_addr, e.addr);
        check("if_valid", 64'(if_valid), 64'(e.valid));
        check("if_pc", if_pc, e.pc);
        check("if_instr", 64'(if_instr), 64'(e.instr));
        check("fetch_fault", 64'(fetch_fault), 64'(e.fault));
    endtask

    initial begin
        reset_n   = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        #2;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_addr", imem_addr, 64'h0);
        check("reset_valid", 64'(if_valid), 64'h0);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("first_valid", 64'(if_valid), 64'h1);
        check("first_pc", if_pc, 64'h0);
        step(0, 0, 0, 0);
        check("addr_8", imem_addr, 64'h8);

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("stall_addr", imem_addr, 64'h8);
        check("stall_pc", if_pc, 64'h4);
        step(0, 0, 0, 0);
        check("resume_pc", if_pc, 64'h8);
        step(0, 0, 0, 0);
        check("addr_10", imem_addr, 64'h10);

        step(0, 0, 1, 64'h40);
        check("br_bubble", 64'(if_valid), 64'h0);
        step(0, 0, 0, 0);
        check("br_target_pc", if_pc, 64'h40);

        step(0, 1, 1, 64'h20);
        check("stall_br_addr", imem_addr, 64'h20);
        check("stall_br_valid", 64'(if_valid), 64'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        step(0, 0, 1, 64'h22);
        check("misalign_fault", 64'(fetch_fault), 64'h1);
        check("misalign_addr", imem_addr, 64'h28);
        step(0, 0, 0, 0);
        step(0, 1, 1, 64'h40);
        step(0, 0, 1, 64'h80);
        check("halt_addr", imem_addr, 64'h28);
        check("halt_valid", 64'(if_valid), 64'h0);

        step(1, 0, 1, 64'h40);
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_fault", 64'(fetch_fault), 64'h1);
        check("wrap_addr", imem_addr, 64'h0);

        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'h400);
        check("oob_fault", 64'(fetch_fault), 64'h1);

        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'h3F0);
        for (int i = 0; i < 8 && m_state == RUN; i++) begin
            step(0, 0, 0, 0);
            check("addr_bound", 64'(imem_addr < 64'd1024), 64'h1);
        end
        check("end_fault", 64'(fetch_fault), 64'h1);
        check("end_valid", 64'(if_valid), 64'h1);
        check("end_pc", if_pc, 64'h3FC);
        check("end_addr", imem_addr, 64'h3FC);
        step(0, 0, 0, 0);
        check("end_bubble", 64'(if_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
